mem_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 43 ++++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/mem_arbiter.sv | 166 ++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared encodings for the byte-serial memory arbiter.
//   SZ_*      request size encodings (3 decodes as a word)
//   IDLE/XFER/DONE  controller state encoding
//   ARB_*     arbitration mode selectors
//   size_bytes / extend  helpers for byte count and read-data extension
package mem_arb_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] XFER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  // Attributes of the transfer in flight, latched at grant.
  typedef struct packed {
    logic       wr;
    logic       sgn;
    logic [2:0] nb;
  } xfer_attr_t;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] d, input logic [2:0] nb,
                                         input logic sgn);
    case (nb)
      3'd1:    return {{24{sgn & d[7]}}, d[7:0]};
      3'd2:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational grant pick.
//   req      request vector
//   last_g   index of the previous grant (round-robin pointer)
//   rr_mode  0 = highest requesting index wins, 1 = first requester after last_g
//   gnt_oh / gnt_idx / gnt_any  one-hot grant, its index, any grant
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last_g,
  input  logic             rr_mode,
  output logic [N-1:0]     gnt_oh,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_any
);

  always_comb begin
    int j;
    j       = 0;
    gnt_oh  = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (rr_mode) begin
      // Search upward from last_g+1 with wrap; last_g itself is checked last.
      for (int i = 1; i <= N; i++) begin
        j = (int'(last_g) + i) % N;
        if (!gnt_any && req[j]) begin
          gnt_oh[j] = 1'b1;
          gnt_idx   = IDX_W'(j);
          gnt_any   = 1'b1;
        end
      end
    end else begin
      // Later iterations overwrite earlier ones, so the highest index wins.
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          gnt_oh    = '0;
          gnt_oh[i] = 1'b1;
          gnt_idx   = IDX_W'(i);
          gnt_any   = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates N_PORTS requesters onto one byte-wide RAM/IO bus,
// serialising 1/2/4-byte reads and writes.
//   clk_in, rst_n_in          clock, async active-low reset
//   rdy_in, io_buffer_full    stall when !rdy_in || io_buffer_full
//   flush                     cancels reads of ports in FLUSH_MASK
//   mem_din/mem_dout/mem_a/mem_wr  RAM bus (read data arrives two edges after address)
//   req_* (per port, packed)  request fields, held until rsp_rdy
//   rsp_rdy, rsp_data         one-hot single-cycle completion, read data
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int                 N_PORTS    = 2,
  parameter int                 ADDR_W     = 32,
  parameter int                 ARB_MODE   = ARB_FIXED,
  parameter logic [N_PORTS-1:0] FLUSH_MASK = '1
) (
  input  logic                    clk_in,
  input  logic                    rst_n_in,
  input  logic                    rdy_in,
  input  logic                    io_buffer_full,
  input  logic                    flush,
  input  logic [7:0]              mem_din,
  output logic [7:0]              mem_dout,
  output logic [ADDR_W-1:0]       mem_a,
  output logic                    mem_wr,
  input  logic [N_PORTS-1:0]      req_en,
  input  logic [N_PORTS-1:0]      req_wr,
  input  logic [2*N_PORTS-1:0]    req_size,
  input  logic [N_PORTS-1:0]      req_signed,
  input  logic [ADDR_W*N_PORTS-1:0] req_addr,
  input  logic [32*N_PORTS-1:0]   req_wdata,
  output logic [N_PORTS-1:0]      rsp_rdy,
  output logic [31:0]             rsp_data
);

  localparam int IDX_W = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

  logic [N_PORTS-1:0][ADDR_W-1:0] p_addr;
  logic [N_PORTS-1:0][31:0]       p_wdata;
  logic [N_PORTS-1:0][1:0]        p_size;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_unpack
    assign p_addr[p]  = req_addr[ADDR_W*p +: ADDR_W];
    assign p_wdata[p] = req_wdata[32*p +: 32];
    assign p_size[p]  = req_size[2*p +: 2];
  end

  logic [1:0]         state;
  logic [IDX_W-1:0]   last_g;
  logic [N_PORTS-1:0] g_oh;
  xfer_attr_t         cur;
  logic [ADDR_W-1:0]  cur_addr;
  logic [31:0]        cur_wdata;
  logic [2:0]         step;     // edges elapsed since the grant edge
  logic [31:0]        rbuf;

  // Flush in IDLE hides masked ports from the arbiter for that cycle.
  logic [N_PORTS-1:0] req_eff;
  logic [N_PORTS-1:0] arb_oh;
  logic [IDX_W-1:0]   arb_idx;
  logic               arb_any;

  assign req_eff = req_en & ~({N_PORTS{flush}} & FLUSH_MASK);

  rr_arbiter #(.N(N_PORTS), .IDX_W(IDX_W)) u_arb (
    .req     (req_eff),
    .last_g  (last_g),
    .rr_mode (ARB_MODE == ARB_RR),
    .gnt_oh  (arb_oh),
    .gnt_idx (arb_idx),
    .gnt_any (arb_any)
  );

  logic        stall;
  logic        cancel;
  logic [31:0] wsh;
  logic [1:0]  cap_idx;
  logic [31:0] rd_next;

  assign stall   = !rdy_in || io_buffer_full;
  // Stores are never torn: only reads of masked ports are cancellable.
  assign cancel  = flush && |(FLUSH_MASK & g_oh) && !cur.wr;
  assign wsh     = cur_wdata >> {step[1:0], 3'b000};
  // mem_din at edge k+2 holds the byte addressed at edge k.
  assign cap_idx = 2'(step - 3'd2);

  always_comb begin
    rd_next = rbuf;
    case (cap_idx)
      2'd0:    rd_next[7:0]   = mem_din;
      2'd1:    rd_next[15:8]  = mem_din;
      2'd2:    rd_next[23:16] = mem_din;
      default: rd_next[31:24] = mem_din;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state     <= IDLE;
      last_g    <= IDX_W'(N_PORTS - 1);
      g_oh      <= '0;
      cur       <= '0;
      cur_addr  <= '0;
      cur_wdata <= '0;
      step      <= '0;
      rbuf      <= '0;
      mem_dout  <= '0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
      rsp_rdy   <= '0;
      rsp_data  <= '0;
    end else if (!stall) begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            g_oh      <= arb_oh;
            last_g    <= arb_idx;
            cur       <= '{wr: req_wr[arb_idx], sgn: req_signed[arb_idx],
                          nb: size_bytes(p_size[arb_idx])};
            cur_addr  <= p_addr[arb_idx];
            cur_wdata <= p_wdata[arb_idx];
            rbuf      <= '0;
            step      <= 3'd1;
            mem_a     <= p_addr[arb_idx];
            mem_wr    <= req_wr[arb_idx];
            if (req_wr[arb_idx]) mem_dout <= p_wdata[arb_idx][7:0];
            state     <= XFER;
          end
        end
        XFER: begin
          if (cancel) begin
            mem_wr <= 1'b0;
            state  <= IDLE;
          end else begin
            step <= step + 3'd1;
            if (cur.wr) begin
              if (step == cur.nb) begin
                mem_wr  <= 1'b0;
                rsp_rdy <= g_oh;
                state   <= DONE;
              end else begin
                mem_a    <= cur_addr + ADDR_W'(step);
                mem_dout <= wsh[7:0];
              end
            end else begin
              if (step < cur.nb)   mem_a <= cur_addr + ADDR_W'(step);
              if (step >= 3'd2)    rbuf  <= rd_next;
              if (step == cur.nb + 3'd1) begin
                rsp_data <= extend(rd_next, cur.nb, cur.sgn);
                rsp_rdy  <= g_oh;
                state    <= DONE;
              end
            end
          end
        end
        DONE: begin
          // One dead cycle lets the requester retire the acknowledged request.
          rsp_rdy <= '0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: table-driven vectors plus hand sequences for flush, stall,
// reset and arbitration. Responses are checked against a scoreboard queue.
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int NP = 2;

  logic clk = 1'b0, rst_n = 1'b0, rdy_in = 1'b1, io_full = 1'b0, flush = 1'b0;

  logic [7:0]       mem_din = 8'h00, mem_dout;
  logic [31:0]      mem_a;
  logic             mem_wr;
  logic [NP-1:0]    req_en = '0, req_wr = '0, req_signed = '0, rsp_rdy;
  logic [2*NP-1:0]  req_size = '0;
  logic [32*NP-1:0] req_addr = '0, req_wdata = '0;
  logic [31:0]      rsp_data;

  // Second instance in fixed-priority mode, used only for grant order.
  logic [7:0]       fx_din = 8'h00, fx_dout;
  logic [31:0]      fx_a, fx_rsp_data;
  logic             fx_wr;
  logic [NP-1:0]    fx_req_en = '0, fx_rsp_rdy;

  always #5 clk = ~clk;

  mem_arbiter #(.N_PORTS(NP), .ADDR_W(32), .ARB_MODE(ARB_RR), .FLUSH_MASK(2'b01)) dut (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .io_buffer_full(io_full),
    .flush(flush), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr), .req_en(req_en), .req_wr(req_wr), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_rdy(rsp_rdy), .rsp_data(rsp_data)
  );

  mem_arbiter #(.N_PORTS(NP), .ADDR_W(32), .ARB_MODE(ARB_FIXED)) dut_fx (
    .clk_in(clk), .rst_n_in(rst_n), .rdy_in(rdy_in), .io_buffer_full(io_full),
    .flush(flush), .mem_din(fx_din), .mem_dout(fx_dout), .mem_a(fx_a),
    .mem_wr(fx_wr), .req_en(fx_req_en), .req_wr(2'b00), .req_size(4'b0000),
    .req_signed(2'b00), .req_addr(64'd0), .req_wdata(64'd0),
    .rsp_rdy(fx_rsp_rdy), .rsp_data(fx_rsp_data)
  );

  // Synchronous RAM; the bus behind io_buffer_full freezes together with the controller.
  logic [7:0] ram [0:4095];
  always @(posedge clk) begin
    if (rdy_in && !io_full) begin
      if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
      mem_din <= ram[mem_a[11:0]];
    end
  end

  int n_pass = 0, n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
  endtask

  typedef struct { int port; logic rd; logic [31:0] data; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; } wev_t;
  exp_t sb_q[$];
  wev_t wlog[$];
  exp_t mon_e;
  int   model_last = NP - 1;

  always @(negedge clk) begin
    if (rst_n && |rsp_rdy) begin
      if (sb_q.size() == 0) check("rsp_unexpected", 32'(rsp_rdy), 32'd0);
      else begin
        mon_e = sb_q.pop_front();
        check("rsp_port", 32'(rsp_rdy), 32'(1) << mon_e.port);
        if (mon_e.rd) check("rsp_data", rsp_data, mon_e.data);
      end
    end
    if (rst_n && mem_wr) wlog.push_back('{mem_a, mem_dout});
  end

  // Issue one request (called at a negedge) and check latency and bus writes.
  // flush_at: -1 none, 0 asserted with the request, k>0 asserted after edge k-1.
  task automatic do_req(input int p, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ex,
                        input int stall_at, input int stall_len, input int flush_at,
                        input int extra);
    int n, cnt, exp_lat;
    logic got, w0;
    logic [31:0] a0;
    exp_t e;
    n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    exp_lat = (wr ? n : n + 1) + stall_len + extra;
    wlog.delete();
    e.port = p; e.rd = !wr; e.data = ex;
    sb_q.push_back(e);
    req_en[p] = 1'b1; req_wr[p] = wr; req_signed[p] = sg;
    req_size[2*p +: 2] = sz; req_addr[32*p +: 32] = a; req_wdata[32*p +: 32] = wd;
    if (flush_at == 0) flush = 1'b1;
    cnt = 0; got = 1'b0; a0 = '0; w0 = 1'b0;
    while (!got && cnt < 60) begin
      @(negedge clk);
      cnt++;
      got = rsp_rdy[p];
      if (flush_at >= 0 && cnt == flush_at + 1) flush = 1'b0;
      if (flush_at > 0 && cnt == flush_at) flush = 1'b1;
      if (stall_len > 0 && cnt == stall_at) begin
        io_full = 1'b1; a0 = mem_a; w0 = mem_wr;
      end
      if (stall_len > 0 && cnt == stall_at + stall_len) begin
        check("stall_mem_a", mem_a, a0);
        check("stall_mem_wr", 32'(mem_wr), 32'(w0));
        io_full = 1'b0;
      end
    end
    io_full = 1'b0; flush = 1'b0;
    check("latency", got ? 32'(cnt - 1) : 32'hFFFF_FFFF, 32'(exp_lat));
    req_en[p] = 1'b0;
    @(negedge clk);
    check("wr_count", 32'(wlog.size()), wr ? 32'(n) : 32'd0);
    if (wr) begin
      for (int k = 0; k < n && k < wlog.size(); k++) begin
        check("wr_addr", wlog[k].a, a + 32'(k));
        check("wr_data", 32'(wlog[k].d), (wd >> (8 * k)) & 32'hFF);
      end
    end
    if (!got) sb_q.delete();
    model_last = p;
  endtask

  typedef struct { int p; logic wr; logic [1:0] sz; logic sg; logic [31:0] a, wd, ex; } vec_t;
  vec_t vecs[15];

  initial begin
    int pulses;
    exp_t e;
    for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
    ram[12'h100] = 8'h78; ram[12'h101] = 8'h56; ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
    ram[12'h300] = 8'h80; ram[12'h310] = 8'h01; ram[12'h311] = 8'h80; ram[12'h202] = 8'hAA;

    vecs[0]  = '{1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0,        32'h12345678};
    vecs[1]  = '{0, 1'b0, 2'd0, 1'b1, 32'h300, 32'h0,        32'hFFFFFF80};
    vecs[2]  = '{0, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0,        32'h00000080};
    vecs[3]  = '{1, 1'b0, 2'd1, 1'b1, 32'h310, 32'h0,        32'hFFFF8001};
    vecs[4]  = '{0, 1'b0, 2'd1, 1'b0, 32'h310, 32'h0,        32'h00008001};
    vecs[5]  = '{1, 1'b1, 2'd1, 1'b0, 32'h200, 32'h0000BEEF, 32'h0};
    vecs[6]  = '{0, 1'b0, 2'd1, 1'b0, 32'h200, 32'h0,        32'h0000BEEF};
    vecs[7]  = '{1, 1'b0, 2'd0, 1'b0, 32'h202, 32'h0,        32'h000000AA};
    vecs[8]  = '{0, 1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{1, 1'b0, 2'd2, 1'b1, 32'h400, 32'h0,        32'hCAFEF00D};
    vecs[10] = '{0, 1'b0, 2'd0, 1'b1, 32'h403, 32'h0,        32'hFFFFFFCA};
    vecs[11] = '{1, 1'b0, 2'd3, 1'b0, 32'h400, 32'h0,        32'hCAFEF00D};
    vecs[12] = '{1, 1'b0, 2'd0, 1'b1, 32'h401, 32'h0,        32'hFFFFFFF0};
    vecs[13] = '{0, 1'b0, 2'd1, 1'b1, 32'h402, 32'h0,        32'hFFFFCAFE};
    vecs[14] = '{1, 1'b1, 2'd0, 1'b0, 32'h204, 32'h12345677, 32'h0};

    // Reset values, observed before any clock edge.
    #3;
    check("rst_mem_dout", 32'(mem_dout), 32'd0);
    check("rst_mem_a",    mem_a,         32'd0);
    check("rst_mem_wr",   32'(mem_wr),   32'd0);
    check("rst_rsp_rdy",  32'(rsp_rdy),  32'd0);
    check("rst_rsp_data", rsp_data,      32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 15; i++)
      do_req(vecs[i].p, vecs[i].wr, vecs[i].sz, vecs[i].sg, vecs[i].a, vecs[i].wd,
             vecs[i].ex, 0, 0, -1, 0);

    // Three stalled cycles mid word read.
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h12345678, 2, 3, -1, 0);
    // Flush in IDLE holds off the masked port for one cycle.
    do_req(0, 1'b0, 2'd0, 1'b0, 32'h300, 32'h0, 32'h00000080, 0, 0, 0, 1);
    // Flush ignored on an unmasked read and on a masked port's write.
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 32'h12345678, 0, 0, 2, 0);
    do_req(0, 1'b1, 2'd2, 1'b0, 32'h500, 32'hA1B2C3D4, 32'h0, 0, 0, 2, 0);
    do_req(1, 1'b0, 2'd2, 1'b0, 32'h500, 32'h0, 32'hA1B2C3D4, 0, 0, -1, 0);

    // Flush cancels a masked word read in flight.
    req_en[0] = 1'b1; req_wr[0] = 1'b0; req_signed[0] = 1'b0;
    req_size[1:0] = 2'd2; req_addr[31:0] = 32'h100;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1; req_en[0] = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    check("flush_state_idle", 32'(dut.state), 32'(IDLE));
    check("flush_mem_wr",     32'(mem_wr),    32'd0);
    pulses = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (|rsp_rdy) pulses++;
    end
    check("flush_no_rsp", 32'(pulses), 32'd0);
    model_last = 0;

    // Asynchronous reset in the middle of a word write.
    req_en[1] = 1'b1; req_wr[1] = 1'b1; req_size[3:2] = 2'd2;
    req_addr[63:32] = 32'h600; req_wdata[63:32] = 32'h11223344;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_wr", 32'(mem_wr), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_mem_wr",   32'(mem_wr),   32'd0);
    check("arst_mem_a",    mem_a,         32'd0);
    check("arst_mem_dout", 32'(mem_dout), 32'd0);
    check("arst_rsp_rdy",  32'(rsp_rdy),  32'd0);
    req_en = '0; req_wr = '0;
    @(negedge clk);
    rst_n = 1'b1;
    sb_q.delete();
    model_last = NP - 1;
    @(negedge clk);

    // Round-robin: both ports request continuously; grants alternate.
    req_wr = '0; req_signed = '0;
    req_size[1:0] = 2'd0; req_addr[31:0]  = 32'h300;
    req_size[3:2] = 2'd1; req_addr[63:32] = 32'h310;
    for (int k = 0; k < 4; k++) begin
      e.port = (model_last + 1 + k) % NP;
      e.rd   = 1'b1;
      e.data = (e.port == 0) ? 32'h00000080 : 32'h00008001;
      sb_q.push_back(e);
    end
    req_en = 2'b11;
    pulses = 0;
    for (int k = 0; k < 80 && pulses < 4; k++) begin
      @(negedge clk);
      if (|rsp_rdy) pulses++;
    end
    req_en = '0;
    check("rr_pulses", 32'(pulses), 32'd4);
    @(negedge clk);
    @(negedge clk);
    check("rr_sb_drained", 32'(sb_q.size()), 32'd0);
    sb_q.delete();

    // Fixed priority: port 1 wins every time, one transfer per 4 cycles.
    fx_req_en = 2'b11;
    pulses = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (|fx_rsp_rdy) begin
        pulses++;
        check("fx_grant", 32'(fx_rsp_rdy), 32'd2);
      end
    end
    fx_req_en = '0;
    check("fx_pulses", 32'(pulses), 32'd5);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
